alu_arbiter: RTL and testbench

//  Shares one combinational ALU between two requesters (port 0: execute stage, port 1: address/branch helper).

---
 rtl/alu_arbiter_pkg.sv | 18 +
 rtl/alu_arbiter_rr_grant2.sv | 15 +
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: state encoding and ALU op codes.
// Op code 0 is deliberately unassigned so the reset value of alu_op yields result 0.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic [3:0] OP_ADDU    = 4'h1;
    localparam logic [3:0] OP_SUBU    = 4'h2;
    localparam logic [3:0] OP_AND     = 4'h3;
    localparam logic [3:0] OP_OR      = 4'h4;
    localparam logic [3:0] OP_SHIFT16 = 4'h5;
    localparam logic [3:0] OP_EQUAL   = 4'h6;

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant: on contention the port that did not win last time is chosen.
module rr_grant2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight.
// state    | meaning
// ARB_IDLE | waiting for a request, req_ready one-hot to the granted port
// ARB_EXEC | latched operands drive the ALU, result captured at end of cycle
// ARB_RESP | resp_valid held to the owner until it asserts resp_ready
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_data1,
    input  logic [2*W-1:0]   req_data2,
    input  logic [2*OPW-1:0] req_op,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [W-1:0]     resp_result,
    output logic             resp_judge,
    output logic [W-1:0]     alu_data1,
    output logic [W-1:0]     alu_data2,
    output logic [OPW-1:0]   alu_op,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_judge
);

    arb_state_e     state, state_next;
    logic [1:0]     grant;
    logic           rr_last;
    logic           owner;
    logic           handshake;
    logic           hs_port;
    logic [W-1:0]   data1_q, data2_q, result_q;
    logic [OPW-1:0] op_q;
    logic           judge_q;

    rr_grant2 u_rr_grant2 (
        .valid   (req_valid),
        .rr_last (rr_last),
        .grant   (grant)
    );

    assign handshake = |(req_valid & req_ready);
    assign hs_port   = grant[1];

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        case (state)
            ARB_IDLE: begin
                req_ready = grant;
                if (handshake) state_next = ARB_EXEC;
            end
            ARB_EXEC: state_next = ARB_RESP;
            ARB_RESP: begin
                resp_valid = owner ? 2'b10 : 2'b01;
                if (resp_ready[owner]) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            rr_last  <= 1'b1;
            owner    <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            judge_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (handshake) begin
                data1_q <= hs_port ? req_data1[2*W-1:W]     : req_data1[W-1:0];
                data2_q <= hs_port ? req_data2[2*W-1:W]     : req_data2[W-1:0];
                op_q    <= hs_port ? req_op[2*OPW-1:OPW]    : req_op[OPW-1:0];
                owner   <= hs_port;
                rr_last <= hs_port;
            end
            if (state == ARB_EXEC) begin
                result_q <= alu_result;
                judge_q  <= alu_judge;
            end
        end
    end

    // ALU inputs come only from registers so requester bus activity never reaches the ALU.
    assign alu_data1   = data1_q;
    assign alu_data2   = data2_q;
    assign alu_op      = op_q;
    assign resp_result = result_q;
    assign resp_judge  = judge_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W   = 32;
    localparam int OPW = 4;

    logic             clk;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*W-1:0]   req_data1;
    logic [2*W-1:0]   req_data2;
    logic [2*OPW-1:0] req_op;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [W-1:0]     resp_result;
    logic             resp_judge;
    logic [W-1:0]     alu_data1;
    logic [W-1:0]     alu_data2;
    logic [OPW-1:0]   alu_op;
    logic [W-1:0]     alu_result;
    logic             alu_judge;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.W(W), .OPW(OPW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data1   (req_data1),
        .req_data2   (req_data2),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_judge  (resp_judge),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_judge   (alu_judge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the shared ALU: unknown op codes give result 0, judge 0.
    always_comb begin
        alu_result = '0;
        alu_judge  = 1'b0;
        case (alu_op)
            OP_ADDU:    alu_result = alu_data1 + alu_data2;
            OP_SUBU:    alu_result = alu_data1 - alu_data2;
            OP_AND:     alu_result = alu_data1 & alu_data2;
            OP_OR:      alu_result = alu_data1 | alu_data2;
            OP_SHIFT16: alu_result = alu_data2 << 16;
            OP_EQUAL:   alu_judge  = (alu_data1 == alu_data2);
            default:    alu_result = '0;
        endcase
    end

    typedef struct {
        int          port;
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp_result;
        logic        exp_judge;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_port(input int port, input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
        if (port == 0) begin
            req_data1[31:0] = d1;
            req_data2[31:0] = d2;
            req_op[3:0]     = op;
        end else begin
            req_data1[63:32] = d1;
            req_data2[63:32] = d2;
            req_op[7:4]      = op;
        end
    endtask

    // Single transaction on one port, response consumed immediately.
    task automatic do_txn(input int port, input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] exp_r, input logic exp_j);
        logic [1:0] onehot;
        onehot = (port == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        set_port(port, op, d1, d2);
        req_valid = onehot;
        #1;
        chk("idle_req_ready", {30'd0, req_ready}, {30'd0, onehot});
        @(negedge clk);
        req_valid = 2'b00;
        set_port(port, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        #1;
        chk("exec_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("exec_alu_op", {28'd0, alu_op}, {28'd0, op});
        chk("exec_alu_data1", alu_data1, d1);
        chk("exec_alu_data2", alu_data2, d2);
        @(negedge clk);
        #1;
        chk("resp_valid", {30'd0, resp_valid}, {30'd0, onehot});
        chk("resp_result", resp_result, exp_r);
        chk("resp_judge", {31'd0, resp_judge}, {31'd0, exp_j});
        chk("resp_req_ready", {30'd0, req_ready}, 32'd0);
        resp_ready = onehot;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("after_resp_valid", {30'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int grants[3];
        int ngrant;

        vecs[0] = '{0, OP_ADDU,    32'd5,        32'd7,        32'd12,         1'b0};
        vecs[1] = '{1, OP_EQUAL,   32'h1234,     32'h1234,     32'd0,          1'b1};
        vecs[2] = '{1, OP_EQUAL,   32'h1234,     32'h1235,     32'd0,          1'b0};
        vecs[3] = '{0, OP_SHIFT16, 32'h0,        32'h0001,     32'h0001_0000,  1'b0};
        vecs[4] = '{1, 4'hF,       32'h55,       32'h66,       32'd0,          1'b0};
        vecs[5] = '{0, OP_AND,     32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00,   1'b0};
        vecs[6] = '{1, OP_SUBU,    32'd3,        32'd5,        32'hFFFF_FFFE,  1'b0};
        vecs[7] = '{0, OP_OR,      32'hF0,       32'h0F,       32'hFF,         1'b0};

        reset_n    = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_data1  = '0;
        req_data2  = '0;
        req_op     = '0;
        #12;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_data1", alu_data1, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].port, vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].exp_result, vecs[i].exp_judge);
        end

        // Both ports continuously valid: grants alternate starting with port 0.
        do_reset();
        set_port(0, OP_SUBU, 32'd10, 32'd3);
        set_port(1, OP_OR, 32'hF0, 32'h0F);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        ngrant = 0;
        for (int c = 0; c < 30 && ngrant < 3; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                grants[ngrant] = req_ready[1] ? 1 : 0;
                ngrant++;
            end
            if (resp_valid[0]) chk("rr_result_p0", resp_result, 32'd7);
            if (resp_valid[1]) chk("rr_result_p1", resp_result, 32'hFF);
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_grant_count", ngrant, 3);
        if (ngrant == 3) begin
            chk("rr_grant0", grants[0], 0);
            chk("rr_grant1", grants[1], 1);
            chk("rr_grant2", grants[2], 0);
        end
        repeat (3) @(negedge clk);
        resp_ready = 2'b00;

        // Owner stalls its response; port 1 waits, its resp_ready is ignored.
        do_reset();
        set_port(0, OP_ADDU, 32'h100, 32'h23);
        set_port(1, OP_ADDU, 32'd1, 32'd1);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_resp_valid", {30'd0, resp_valid}, 32'd1);
            chk("stall_result", resp_result, 32'h123);
            chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 2'b01;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("stall_next_grant", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("stall_p1_valid", {30'd0, resp_valid}, 32'd2);
        chk("stall_p1_result", resp_result, 32'd2);
        resp_ready = 2'b10;
        @(negedge clk);
        resp_ready = 2'b00;

        // Reset asserted while an op from port 0 is executing.
        set_port(0, OP_ADDU, 32'd9, 32'd9);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("pre_rst_alu_data1", alu_data1, 32'd9);
        reset_n = 1'b0;
        #1;
        chk("midrst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("midrst_result", resp_result, 32'd0);
        chk("midrst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("midrst_alu_data1", alu_data1, 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        resp_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("postrst_no_resp", {30'd0, resp_valid}, 32'd0);
        end
        resp_ready = 2'b00;
        req_valid  = 2'b11;
        #1;
        chk("postrst_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
